// File: rtl/mastermind_pkg.sv
// Shared constants and types for the Mastermind codemaker.
// FIXED_CODE is the bring-up secret (1,2,3,4 from peg0) used when FIXED_SECRET_EN is defined.
package mastermind_pkg;

    localparam int NUM_PEGS   = 4;
    localparam int COLOR_W    = 3;
    localparam int MAX_TRIES  = 10;
    localparam int NUM_COLORS = 1 << COLOR_W;
    localparam int CODE_W     = NUM_PEGS * COLOR_W;
    localparam int CNT_MAX    = (NUM_PEGS > NUM_COLORS) ? NUM_PEGS : NUM_COLORS;
    localparam int CNT_W      = $clog2(CNT_MAX);

    typedef logic [COLOR_W-1:0] peg_t;
    typedef peg_t [NUM_PEGS-1:0] code_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        EXACT,
        COLOR,
        REPORT,
        DONE
    } state_t;

    function automatic code_t fixed_code();
        code_t c;
        for (int i = 0; i < NUM_PEGS; i++) c[i] = peg_t'(i + 1);
        return c;
    endfunction

    localparam code_t FIXED_CODE = fixed_code();

endpackage

// File: rtl/mastermind_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right.
// Only the low OUT_W bits are exported as the random source.
module mastermind_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mastermind_code_master.sv
// Mastermind codemaker: holds the secret, scores one guess per handshake sequentially.
// Define FIXED_SECRET_EN to load the constant FIXED_CODE instead of LFSR bits.
module mastermind_code_master
    import mastermind_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic              guess_valid,
    output logic              guess_ready,
    input  logic [CODE_W-1:0] guess,
    output logic              score_valid,
    output logic [2:0]        black,
    output logic [2:0]        white,
    output logic [3:0]        tries,
    output logic              win,
    output logic              lose,
    output logic              busy
);

    state_t            state_q, state_d;
    code_t             secret_q, secret_d;
    code_t             guess_q, guess_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        acc_black_q, acc_black_d;
    logic [2:0]        acc_sum_q, acc_sum_d;
    logic [2:0]        black_q, black_d;
    logic [2:0]        white_q, white_d;
    logic [3:0]        tries_q, tries_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [CODE_W-1:0] rnd;

    mastermind_lfsr #(.SEED(LFSR_SEED), .OUT_W(CODE_W)) u_lfsr (
        .clk   (MAX10_CLK1_50),
        .rst_n (rst_n),
        .rnd   (rnd)
    );

    // Per-cycle datapath: cnt_q selects the peg in EXACT and the colour in COLOR.
    logic       peg_hit;
    logic [2:0] n_sec, n_gss, min_cnt, sum_next;
    logic [3:0] tries_inc;

    always_comb begin
        peg_hit = 1'b0;
        n_sec   = '0;
        n_gss   = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (cnt_q == CNT_W'(i)) peg_hit = (secret_q[i] == guess_q[i]);
            n_sec = n_sec + 3'(secret_q[i] == peg_t'(cnt_q));
            n_gss = n_gss + 3'(guess_q[i] == peg_t'(cnt_q));
        end
        min_cnt   = (n_sec < n_gss) ? n_sec : n_gss;
        sum_next  = acc_sum_q + min_cnt;
        tries_inc = tries_q + 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        cnt_d       = cnt_q;
        acc_black_d = acc_black_q;
        acc_sum_d   = acc_sum_q;
        black_d     = black_q;
        white_d     = white_q;
        tries_d     = tries_q;
        win_d       = win_q;
        lose_d      = lose_q;
        if (new_game) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
`ifdef FIXED_SECRET_EN
                    secret_d = FIXED_CODE;
`else
                    secret_d = code_t'(rnd);
`endif
                    tries_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    black_d = '0;
                    white_d = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (guess_valid) begin
                        guess_d     = code_t'(guess);
                        cnt_d       = '0;
                        acc_black_d = '0;
                        acc_sum_d   = '0;
                        state_d     = EXACT;
                    end
                end
                EXACT: begin
                    acc_black_d = acc_black_q + 3'(peg_hit);
                    if (cnt_q == CNT_W'(NUM_PEGS - 1)) begin
                        cnt_d   = '0;
                        state_d = COLOR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COLOR: begin
                    acc_sum_d = sum_next;
                    // Results land on entry to REPORT so they are valid with score_valid.
                    if (cnt_q == CNT_W'(NUM_COLORS - 1)) begin
                        cnt_d   = '0;
                        state_d = REPORT;
                        black_d = acc_black_q;
                        white_d = sum_next - acc_black_q;
                        tries_d = tries_inc;
                        if (acc_black_q == 3'(NUM_PEGS))       win_d  = 1'b1;
                        else if (tries_inc == 4'(MAX_TRIES))   lose_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPORT:  state_d = (win_q || lose_q) ? DONE : WAIT;
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            cnt_q       <= '0;
            acc_black_q <= '0;
            acc_sum_q   <= '0;
            black_q     <= '0;
            white_q     <= '0;
            tries_q     <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            cnt_q       <= cnt_d;
            acc_black_q <= acc_black_d;
            acc_sum_q   <= acc_sum_d;
            black_q     <= black_d;
            white_q     <= white_d;
            tries_q     <= tries_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    assign guess_ready = (state_q == WAIT);
    assign score_valid = (state_q == REPORT);
    assign busy        = (state_q == EXACT) || (state_q == COLOR) || (state_q == REPORT);
    assign black       = black_q;
    assign white       = white_q;
    assign tries       = tries_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule
